light_sequencer: RTL and testbench
==================================

// Module: light_sequencer
// PURPOSE
//  Controller for the white/RGB light selector.
//  - Generates the select line and the 24-bit RGB colour word that feed the selector.
//  - Two debounced-upstream push buttons drive a 3-state mode FSM: WHITE, MANUAL, AUTO.
//    - MANUAL: colour steps once per press.
//    - AUTO: colour steps on a fixed clock divider.
// PARAMETERS
//  TICK_DIV   4   clocks per colour step in AUTO; legal range >=2. Counter width = $clog2(TICK_DIV).
// PORTS
//  clk       in   1   system clock, rising edge.
//  rst       in   1   asynchronous, active-high reset.
//  mode_btn  in   1   mode button, level; a rising edge advances the mode.
//  step_btn  in   1   step button, level; a rising edge advances the colour (MANUAL only).
//  sel       out  1   to selector: 0 = white, 1 = rgb.
//  rgb       out  24  colour word to selector, {R[7:0],G[7:0],B[7:0]}.
//  colour    out  3   current colour index, 1..6.
//  state     out  2   mode: 00 WHITE, 01 MANUAL, 10 AUTO; 11 is never produced.
// BEHAVIOUR
//  Reset (async, immediate): state=WHITE, sel=0, colour=1, rgb=24'h0000FF, counter=0.
//   Both button history regs reset to 1, so a button held through reset release is NOT an edge.
//  Edge detect: rise_x = x_btn & ~x_btn_q. x_btn_q <= x_btn every clock.
//   A level held for N cycles gives exactly one rise.
//  All outputs are registered and change only on a clk edge (or on rst).
//   Latency: an input rising before edge k takes effect on the outputs after edge k.
//  Mode FSM on rise_mode: WHITE->MANUAL->AUTO->WHITE.
//   sel = 0 in WHITE, 1 in MANUAL and AUTO. sel is registered with state.
//  Colour sequence: 1,2,3,4,5,6,1,... Index 0 and 7 are never produced; 6 wraps to 1.
//  rgb = {{8{colour[2]}},{8{colour[1]}},{8{colour[0]}}}.
//   rgb is registered and updates on the same edge as colour, so rgb always matches colour.
//   1=0000FF  2=00FF00  3=00FFFF  4=FF0000  5=FF00FF  6=FFFF00.
//  WHITE: colour and counter are held; rise_step is ignored.
//  MANUAL: on rise_step the colour advances once; the counter is held at 0.
//  AUTO:
//   - The counter increments every clock.
//   - When counter==TICK_DIV-1: counter<=0 and the colour advances. Period = TICK_DIV clocks.
//   - rise_step is ignored.
//  Entering AUTO clears the counter, so the first step comes TICK_DIV clocks after the mode edge.
//  Leaving AUTO holds the colour value and clears the counter.
//  Simultaneous rise_mode and rise_step: the mode change wins and the step is discarded.
//   Example: MANUAL + both -> AUTO with colour unchanged.
//  Simultaneous rise_mode and AUTO terminal count: the mode change wins; colour does not advance.
//  rst asserted mid-operation: reset values apply at once regardless of clk.
//   Normal operation resumes on the first clk edge after rst deasserts.
// TESTING
//  1 rst=1 pulse, buttons low -> sel=0, state=00, colour=1, rgb=24'h0000FF, with no clk edge needed.
//  2 1 mode press, then 6 step presses -> state=01, sel=1; colour 2,3,4,5,6,1;
//    rgb 00FF00,00FFFF,FF0000,FF00FF,FFFF00,0000FF.
//  3 TICK_DIV=4, 2nd mode press -> state=10; colour advances every 4 clks, first 4 clks after edge;
//    step presses cause no change. 3rd press -> WHITE, sel=0, colour frozen.
//  4 In MANUAL, mode_btn and step_btn rise on the same cycle -> state=10, colour unchanged.
//    Step press in WHITE -> colour unchanged.
//  5 step_btn held high for 10 clks in MANUAL -> exactly one advance.
//    mode_btn held high across rst release -> state stays WHITE.
//  6 rst asserted mid-AUTO with colour=5 between clk edges -> immediate WHITE, colour=1, rgb=0000FF.
//    After release, a mode press re-enters MANUAL correctly.

Source files
------------

// File: rtl/light_sequencer.sv
// ----------------------------------------------------------------------------
// light_sequencer
//
// Controller for the white/RGB light selector. It produces the select line
// and the 24-bit colour word for the selector. Two push buttons drive a
// three-mode FSM:
//   WHITE  : the selector shows white; colour and divider are frozen.
//   MANUAL : the colour steps once per step-button press.
//   AUTO   : the colour steps every TICK_DIV clocks.
//
// Both buttons are already debounced upstream. Each button produces one
// rising edge per press, however long the button is held.
//
// Parameters
//   TICK_DIV  clocks per colour step in AUTO (legal range >= 2)
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous, active-high reset
//   mode_btn  in   1   mode button level; a rising edge advances the mode
//   step_btn  in   1   step button level; a rising edge advances the colour
//                      (MANUAL only)
//   sel       out  1   0 = white, 1 = rgb
//   rgb       out  24  {R[7:0],G[7:0],B[7:0]}; each channel is fully on or off
//   colour    out  3   current colour index, always in 1..6
//   state     out  2   00 WHITE, 01 MANUAL, 10 AUTO
// ----------------------------------------------------------------------------
module light_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_btn,
  input  logic        step_btn,
  output logic        sel,
  output logic [23:0] rgb,
  output logic [2:0]  colour,
  output logic [1:0]  state
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    WHITE  = 2'b00,
    MANUAL = 2'b01,
    AUTO   = 2'b10
  } mode_e;

  mode_e         mode_q;
  logic [CW-1:0] cnt_q;
  logic          mode_btn_q;
  logic          step_btn_q;
  logic          rise_mode;
  logic          rise_step;

  // The colour index runs 1..6. Index 6 wraps to 1, so 0 and 7 never appear.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == 3'd6) ? 3'd1 : c + 3'd1;
  endfunction

  // Each bit of the colour index switches one 8-bit channel fully on.
  function automatic logic [23:0] to_rgb(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  assign rise_mode = mode_btn & ~mode_btn_q;
  assign rise_step = step_btn & ~step_btn_q;
  assign state     = mode_q;

  // NOTE: state registers use non-blocking assignments. Every branch then
  // reads the values from before this edge, whatever order the code is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= WHITE;
      sel        <= 1'b0;
      colour     <= 3'd1;
      rgb        <= 24'h0000FF;
      cnt_q      <= '0;
      // History resets high, so a button held through reset release is not
      // taken as a press.
      mode_btn_q <= 1'b1;
      step_btn_q <= 1'b1;
    end else begin
      mode_btn_q <= mode_btn;
      step_btn_q <= step_btn;

      if (rise_mode) begin
        // A mode change has priority over a step press and over the AUTO
        // terminal count on the same edge. Clearing the divider here means
        // the first AUTO step comes a full period after entry.
        cnt_q <= '0;
        unique case (mode_q)
          WHITE: begin
            mode_q <= MANUAL;
            sel    <= 1'b1;
          end
          MANUAL: begin
            mode_q <= AUTO;
            sel    <= 1'b1;
          end
          default: begin
            mode_q <= WHITE;
            sel    <= 1'b0;
          end
        endcase
      end else begin
        unique case (mode_q)
          MANUAL: begin
            if (rise_step) begin
              colour <= next_colour(colour);
              rgb    <= to_rgb(next_colour(colour));
            end
          end
          AUTO: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q  <= '0;
              colour <= next_colour(colour);
              rgb    <= to_rgb(next_colour(colour));
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            // WHITE holds colour and divider.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// ----------------------------------------------------------------------------
// tb_light_sequencer
//
// Directed bench for light_sequencer with TICK_DIV = 4. A behavioural model
// tracks mode, colour and clocks-since-last-step as plain integers, and it
// takes rgb from a colour table. A compare process checks every DUT output
// against the model on each falling clock edge. Directed sections add
// hand-computed literal checks at the key points of each scenario.
// ----------------------------------------------------------------------------
module tb_light_sequencer;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic        sel;
  logic [23:0] rgb;
  logic [2:0]  colour;
  logic [1:0]  state;

  int vectors     = 0;
  int miscompares = 0;

  light_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_btn (mode_btn),
    .step_btn (step_btn),
    .sel      (sel),
    .rgb      (rgb),
    .colour   (colour),
    .state    (state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Colour table indexed by the colour number; entry 0 is never used.
  logic [23:0] lut [0:6] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                             24'hFF0000, 24'hFF00FF, 24'hFFFF00};
  int m_mode   = 0;  // 0 WHITE, 1 MANUAL, 2 AUTO
  int m_colour = 1;
  int m_since  = 0;  // clocks spent in AUTO since entry or the last step
  bit m_mprev  = 1'b1;
  bit m_sprev  = 1'b1;

  always @(posedge clk or posedge rst) begin
    bit mr, sr;
    if (rst) begin
      m_mode   = 0;
      m_colour = 1;
      m_since  = 0;
      m_mprev  = 1'b1;
      m_sprev  = 1'b1;
    end else begin
      mr = mode_btn && !m_mprev;
      sr = step_btn && !m_sprev;
      m_mprev = mode_btn;
      m_sprev = step_btn;
      if (mr) begin
        m_mode  = (m_mode + 1) % 3;
        m_since = 0;
      end else if (m_mode == 1) begin
        if (sr) m_colour = m_colour % 6 + 1;
      end else if (m_mode == 2) begin
        m_since++;
        if (m_since == TICK_DIV) begin
          m_since  = 0;
          m_colour = m_colour % 6 + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Checks every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_state",  {22'd0, state},  24'(m_mode));
    check("model_sel",    {23'd0, sel},    (m_mode != 0) ? 24'd1 : 24'd0);
    check("model_colour", {21'd0, colour}, 24'(m_colour));
    check("model_rgb",    rgb,             lut[m_colour]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_mode();
    cycles(1);
    mode_btn = 1'b1;
    cycles(1);
    mode_btn = 1'b0;
  endtask

  task automatic press_step();
    cycles(1);
    step_btn = 1'b1;
    cycles(1);
    step_btn = 1'b0;
  endtask

  logic [2:0]  exp_col [0:5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
  logic [23:0] exp_rgb [0:5] = '{24'h00FF00, 24'h00FFFF, 24'hFF0000,
                                 24'hFF00FF, 24'hFFFF00, 24'h0000FF};

  initial begin
    // 1: reset takes effect with no clock edge (first posedge is at t=5).
    #2 rst = 1'b1;
    #1;
    check("rst_sel",    {23'd0, sel},    24'd0);
    check("rst_state",  {22'd0, state},  24'd0);
    check("rst_colour", {21'd0, colour}, 24'd1);
    check("rst_rgb",    rgb,             24'h0000FF);
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // 2: MANUAL, six step presses walk the full sequence and wrap.
    press_mode();
    check("man_state", {22'd0, state}, 24'd1);
    check("man_sel",   {23'd0, sel},   24'd1);
    for (int i = 0; i < 6; i++) begin
      press_step();
      check("man_colour", {21'd0, colour}, {21'd0, exp_col[i]});
      check("man_rgb",    rgb,             exp_rgb[i]);
    end

    // 5a: step held for 10 clocks gives exactly one advance (1 -> 2).
    cycles(1);
    step_btn = 1'b1;
    cycles(10);
    step_btn = 1'b0;
    cycles(2);
    check("hold_step_colour", {21'd0, colour}, 24'd2);

    // 4a: both buttons rise together in MANUAL: AUTO, colour unchanged.
    cycles(1);
    mode_btn = 1'b1;
    step_btn = 1'b1;
    cycles(1);
    mode_btn = 1'b0;
    step_btn = 1'b0;
    check("both_state",  {22'd0, state},  24'd2);
    check("both_colour", {21'd0, colour}, 24'd2);

    // 3: the first AUTO step lands 4 clocks after the entry edge.
    cycles(3);
    check("auto_pre_step", {21'd0, colour}, 24'd2);
    cycles(1);
    check("auto_step1", {21'd0, colour}, 24'd3);
    check("auto_rgb1",  rgb,             24'h00FFFF);
    press_step();   // ignored in AUTO; the model checks each cycle
    cycles(6);
    press_step();
    cycles(5);

    // 3: third mode press returns to WHITE, then colour is frozen.
    press_mode();
    check("white_state", {22'd0, state}, 24'd0);
    check("white_sel",   {23'd0, sel},   24'd0);
    cycles(8);
    // 4b: step press in WHITE changes nothing.
    press_step();
    cycles(3);

    // Mode edge on the AUTO terminal count: mode wins, no advance.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    press_mode();
    press_mode();           // AUTO entered on edge E, colour 1
    cycles(3);              // now just after edge E+3
    mode_btn = 1'b1;        // rises at E+4, the terminal count
    cycles(1);
    mode_btn = 1'b0;
    check("tc_mode_state",  {22'd0, state},  24'd0);
    check("tc_mode_colour", {21'd0, colour}, 24'd1);
    cycles(2);

    // 6: async reset mid-AUTO with colour 5.
    press_mode();
    press_mode();           // AUTO on edge E, colour 1
    cycles(16);             // steps at E+4, +8, +12, +16 -> colour 5
    #2;
    check("pre_rst_colour", {21'd0, colour}, 24'd5);
    check("pre_rst_state",  {22'd0, state},  24'd2);
    rst = 1'b1;
    #1;
    check("midrst_state",  {22'd0, state},  24'd0);
    check("midrst_sel",    {23'd0, sel},    24'd0);
    check("midrst_colour", {21'd0, colour}, 24'd1);
    check("midrst_rgb",    rgb,             24'h0000FF);

    // 5b: mode held high across reset release is not a press.
    mode_btn = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(4);
    check("held_rst_state", {22'd0, state}, 24'd0);
    mode_btn = 1'b0;
    cycles(2);
    check("held_rel_state", {22'd0, state}, 24'd0);

    // 6: a fresh press after reset enters MANUAL correctly.
    press_mode();
    check("post_rst_state", {22'd0, state}, 24'd1);
    check("post_rst_sel",   {23'd0, sel},   24'd1);
    press_step();
    check("post_rst_colour", {21'd0, colour}, 24'd2);
    check("post_rst_rgb",    rgb,             24'h00FF00);
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
